dmem_io: RTL and testbench
==========================

DMEM_IO -- requirements
Module: dmem_io

Interface
REQ-001 Parameter RAM_WORDS, default 128, number of 16-bit data RAM words; power of two, at most 128.
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dmemaddr  input  16  byte address from the EX/MEM register; bit 0 ignored.
REQ-005 dmemwdata  input  16  store data.
REQ-006 dmemwrite  input  1  store enable, sampled at posedge.
REQ-007 dmemread  input  1  load enable.
REQ-008 dmemrdata  output  16  load data, combinational from dmemaddr, valid in the same cycle.
REQ-009 switches  input  8  asynchronous external input port.
REQ-010 leds  output  8  registered output port.
REQ-011 timer_irq  output  1  equals the status match flag.

Function
REQ-012 Address map (word-aligned):
- 0x0000 to 2*RAM_WORDS-2: RAM, word index dmemaddr[7:1]
- 0xFF00 LED (RW, bits 7:0)
- 0xFF02 SWITCH (RO)
- 0xFF04 COUNT (RW)
- 0xFF06 COMPARE (RW)
- 0xFF08 STATUS (bit0 match, write-1-to-clear)
- 0xFF0A CONTROL (bit0 enable)
REQ-013 Unmapped addresses: reads return 0x0000; writes have no effect.
REQ-014 Reads are combinational with zero latency; dmemrdata=0x0000 whenever dmemread=0.
REQ-015 A write with dmemwrite=1 takes effect at that posedge; the new value is visible to a read in the next cycle.
REQ-016 dmemwrite=1 and dmemread=1 in the same cycle at the same address: the read returns the old value.
REQ-017 Narrow registers (LED, CONTROL, STATUS) read back zero-extended and ignore upper write bits.
REQ-018 SWITCH passes through a 2-flop synchronizer, giving 2 cycles of latency from a pin change to the readable value.
REQ-019 While CONTROL.enable=1, COUNT increments by 1 every cycle and wraps from 0xFFFF to 0x0000 without a flag.
REQ-020 A write to COUNT in a cycle in which it would also increment loads the written value exactly; no increment occurs that cycle.
REQ-021 The match flag sets at the posedge following any cycle with enable=1 and COUNT==COMPARE.
REQ-022 A simultaneous match-set and write-1-to-clear leaves the flag set; a STATUS write with bit0=0 has no effect.
REQ-023 Clearing enable freezes COUNT and suppresses new matches; an already-set flag is held.
REQ-024 The timer and IO state machine is implicit (IDLE when enable=0, COUNTING when enable=1), with transitions only via CONTROL writes or reset.

Reset
REQ-025 At reset:
- LED=0x00, COUNT=0x0000, COMPARE=0xFFFF, STATUS=0, CONTROL=0
- both synchronizer flops=0
- leds=0x00, timer_irq=0
REQ-026 RAM contents are not cleared by reset.
REQ-027 Reset asserted mid-count wins over any concurrent write or increment in that cycle.

Structure
REQ-028 The address-map constants (base addresses, register offsets, RAM_WORDS default) belong in the shared PMIPSL definitions include file, used by the CPU testbench and this block.
REQ-029 The timer (COUNT, COMPARE, enable, match flag) is one sub-module named mmio_timer; address decode, RAM, LED and synchronizer stay in dmem_io.

Verification
REQ-030 Write 0x1234 to RAM address 0x0010, then read it with dmemread=1 -> 0x1234 the next cycle; read 0x0011 -> 0x1234.
REQ-031 Read 0x0200 and 0xFF0C -> 0x0000; write 0xFFFF to 0xFF0C -> no register changes.
REQ-032 Set COMPARE=0x0005, COUNT=0x0000, enable=1 -> timer_irq rises exactly 6 cycles after the enable write edge; write 0x0001 to STATUS -> cleared next cycle.
REQ-033 Set COUNT=0xFFFE with enable=1 -> reads 0xFFFF, then 0x0000 (no flag, COMPARE=0x1234); write COUNT=0x0100 during counting -> next read 0x0100.
REQ-034 Change switches 0x00->0xA5 -> reading 0xFF02 returns 0x0000 for 2 cycles, then 0x00A5; write 0x1FF to LED -> leds=0xFF and readback 0x00FF.
REQ-035 Assert reset while counting with a write to LED in the same cycle -> LED=0x00, COUNT=0, timer_irq=0, and a previously written RAM word is still readable.

Source files
------------

// File: rtl/dmem_io_pkg.sv
// Shared address map and reset constants for the data-memory / MMIO block.
// Imported by dmem_io, mmio_timer and the CPU-level benches.
package dmem_io_pkg;

  localparam int RAM_WORDS_DEF = 128;

  localparam logic [11:0] IO_PAGE = 12'hFF0;

  typedef enum logic [2:0] {
    R_LED     = 3'd0,
    R_SWITCH  = 3'd1,
    R_COUNT   = 3'd2,
    R_COMPARE = 3'd3,
    R_STATUS  = 3'd4,
    R_CONTROL = 3'd5
  } io_reg_e;

  localparam logic [15:0] COUNT_RST   = 16'h0000;
  localparam logic [15:0] COMPARE_RST = 16'hFFFF;

endpackage

// File: rtl/mmio_timer.sv
// Free-running compare timer: COUNT, COMPARE, enable and sticky match flag.
// Idle while enable=0, counting while enable=1; only CONTROL writes move it.
module mmio_timer
  import dmem_io_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic        we_status,
  input  logic        we_control,
  input  logic [15:0] wdata,
  output logic [15:0] count,
  output logic [15:0] compare,
  output logic        match,
  output logic        enable
);

  logic hit;

  assign hit = enable && (count == compare);

  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= COUNT_RST;
      compare <= COMPARE_RST;
      match   <= 1'b0;
      enable  <= 1'b0;
    end else begin
      if (we_count)
        count <= wdata;
      else if (enable)
        count <= count + 16'd1;
      if (we_compare)
        compare <= wdata;
      if (we_control)
        enable <= wdata[0];
      // a new match outranks a same-cycle clear
      if (hit)
        match <= 1'b1;
      else if (we_status && wdata[0])
        match <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_io.sv
// Data memory with memory-mapped LED, switch input and compare timer.
// Reads are combinational; all writes land at the clock edge.
module dmem_io
  import dmem_io_pkg::*;
#(
  parameter int RAM_WORDS = RAM_WORDS_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] dmemrdata,
  input  logic [7:0]  switches,
  output logic [7:0]  leds,
  output logic        timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [15:0]   ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic          ram_hit;
  logic          io_hit;
  logic [2:0]    reg_idx;
  logic          wr_io;
  logic          we_led, we_count, we_compare;
  logic          we_status, we_control;
  logic [7:0]    sync1, sync2;
  logic [15:0]   count, compare;
  logic          match, enable;
  logic [15:0]   rd;
  logic          unused_addr0;

  assign unused_addr0 = dmemaddr[0];

  assign ram_idx = dmemaddr[AW:1];
  assign ram_hit = (dmemaddr[15:AW+1] == '0);
  assign reg_idx = dmemaddr[3:1];
  assign io_hit  = (dmemaddr[15:4] == IO_PAGE)
                && (reg_idx <= 3'(R_CONTROL));
  assign wr_io   = dmemwrite && io_hit;

  assign we_led     = wr_io && (reg_idx == 3'(R_LED));
  assign we_count   = wr_io && (reg_idx == 3'(R_COUNT));
  assign we_compare = wr_io && (reg_idx == 3'(R_COMPARE));
  assign we_status  = wr_io && (reg_idx == 3'(R_STATUS));
  assign we_control = wr_io && (reg_idx == 3'(R_CONTROL));

  // RAM keeps its contents across reset
  always_ff @(posedge clock) begin
    if (dmemwrite && ram_hit)
      ram[ram_idx] <= dmemwdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      leds  <= 8'h00;
      sync1 <= 8'h00;
      sync2 <= 8'h00;
    end else begin
      sync1 <= switches;
      sync2 <= sync1;
      if (we_led)
        leds <= dmemwdata[7:0];
    end
  end

  mmio_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .we_count   (we_count),
    .we_compare (we_compare),
    .we_status  (we_status),
    .we_control (we_control),
    .wdata      (dmemwdata),
    .count      (count),
    .compare    (compare),
    .match      (match),
    .enable     (enable)
  );

  assign timer_irq = match;

  always_comb begin
    rd = 16'h0000;
    if (ram_hit) begin
      rd = ram[ram_idx];
    end else if (io_hit) begin
      case (reg_idx)
        3'(R_LED):     rd = {8'h00, leds};
        3'(R_SWITCH):  rd = {8'h00, sync2};
        3'(R_COUNT):   rd = count;
        3'(R_COMPARE): rd = compare;
        3'(R_STATUS):  rd = {15'h0000, match};
        3'(R_CONTROL): rd = {15'h0000, enable};
        default:       rd = 16'h0000;
      endcase
    end
    dmemrdata = dmemread ? rd : 16'h0000;
  end

endmodule

// File: tb/tb_dmem_io.sv
// Bench for dmem_io: table of write/readback vectors plus
// hand-written timer, synchronizer and reset sequences.
module tb_dmem_io;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] dmemaddr;
  logic [15:0] dmemwdata;
  logic        dmemwrite;
  logic        dmemread;
  logic [15:0] dmemrdata;
  logic [7:0]  switches;
  logic [7:0]  leds;
  logic        timer_irq;

  int vectors = 0;
  int fails   = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] wa;
    logic [15:0] wd;
    logic [15:0] ra;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[10];

  dmem_io dut (
    .clock     (clock),
    .reset     (reset),
    .dmemaddr  (dmemaddr),
    .dmemwdata (dmemwdata),
    .dmemwrite (dmemwrite),
    .dmemread  (dmemread),
    .dmemrdata (dmemrdata),
    .switches  (switches),
    .leds      (leds),
    .timer_irq (timer_irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    dmemaddr  = a;
    dmemwdata = d;
    dmemwrite = 1'b1;
    dmemread  = 1'b0;
    step();
    dmemwrite = 1'b0;
  endtask

  task automatic rd(input string name,
                    input logic [15:0] a,
                    input logic [15:0] exp);
    logic [15:0] e;
    dmemaddr  = a;
    dmemwrite = 1'b0;
    dmemread  = 1'b1;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    check(name, dmemrdata, e);
    step();
    dmemread = 1'b0;
  endtask

  initial begin
    tbl[0] = '{16'h0010, 16'h1234, 16'h0010, 16'h1234};
    tbl[1] = '{16'h0012, 16'hBEEF, 16'h0011, 16'h1234};
    tbl[2] = '{16'h00FE, 16'hA5A5, 16'h00FF, 16'hA5A5};
    tbl[3] = '{16'h0000, 16'h0F0F, 16'h0000, 16'h0F0F};
    tbl[4] = '{16'h0200, 16'h5555, 16'h0200, 16'h0000};
    tbl[5] = '{16'h0100, 16'h7777, 16'h0000, 16'h0F0F};
    tbl[6] = '{16'hFF0C, 16'hFFFF, 16'hFF0C, 16'h0000};
    tbl[7] = '{16'hFF00, 16'h01FF, 16'hFF00, 16'h00FF};
    tbl[8] = '{16'hFF06, 16'h4321, 16'hFF06, 16'h4321};
    tbl[9] = '{16'hFF00, 16'h005A, 16'hFF00, 16'h005A};

    reset     = 1'b1;
    dmemaddr  = 16'h0000;
    dmemwdata = 16'h0000;
    dmemwrite = 1'b0;
    dmemread  = 1'b0;
    switches  = 8'h00;
    step();
    step();
    reset = 1'b0;

    check("rst_leds", {8'h00, leds}, 16'h0000);
    check("rst_irq", {15'h0, timer_irq}, 16'h0000);
    rd("rst_led", 16'hFF00, 16'h0000);
    rd("rst_count", 16'hFF04, 16'h0000);
    rd("rst_compare", 16'hFF06, 16'hFFFF);
    rd("rst_status", 16'hFF08, 16'h0000);
    rd("rst_control", 16'hFF0A, 16'h0000);
    rd("rst_switch", 16'hFF02, 16'h0000);

    foreach (tbl[i]) begin
      wr(tbl[i].wa, tbl[i].wd);
      rd($sformatf("table[%0d]", i), tbl[i].ra, tbl[i].exp);
    end
    rd("ram_word0_kept", 16'h0000, 16'h0F0F);
    rd("unmapped_no_compare", 16'hFF06, 16'h4321);

    dmemaddr = 16'h0010;
    dmemread = 1'b0;
    #1;
    check("read_low_zero", dmemrdata, 16'h0000);
    step();

    // same-cycle read and write returns the old word
    dmemaddr  = 16'h0010;
    dmemwdata = 16'h9999;
    dmemwrite = 1'b1;
    dmemread  = 1'b1;
    #1;
    check("rw_old", dmemrdata, 16'h1234);
    step();
    dmemwrite = 1'b0;
    rd("rw_new", 16'h0010, 16'h9999);

    wr(16'hFF06, 16'h0005);
    wr(16'hFF04, 16'h0000);
    wr(16'hFF0A, 16'h0001);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) check("irq_early", {15'h0, timer_irq}, 16'h0000);
      if (k == 6) check("irq_rise", {15'h0, timer_irq}, 16'h0001);
    end
    wr(16'hFF08, 16'h0000);
    check("w0_no_clear", {15'h0, timer_irq}, 16'h0001);
    rd("status_set", 16'hFF08, 16'h0001);
    wr(16'hFF08, 16'h0001);
    check("irq_cleared", {15'h0, timer_irq}, 16'h0000);

    wr(16'hFF06, 16'h0200);
    wr(16'hFF04, 16'h0200);
    wr(16'hFF08, 16'h0001);
    check("set_beats_clr", {15'h0, timer_irq}, 16'h0001);
    wr(16'hFF08, 16'h0001);
    check("clr_after", {15'h0, timer_irq}, 16'h0000);

    wr(16'hFF0A, 16'h0000);
    wr(16'hFF04, 16'h0050);
    step();
    step();
    rd("frozen", 16'hFF04, 16'h0050);
    wr(16'hFF06, 16'h0050);
    step();
    step();
    check("no_match_off", {15'h0, timer_irq}, 16'h0000);

    wr(16'hFF06, 16'h1234);
    wr(16'hFF04, 16'hFFFD);
    wr(16'hFF0A, 16'h0001);
    rd("cnt_fffd", 16'hFF04, 16'hFFFD);
    rd("cnt_fffe", 16'hFF04, 16'hFFFE);
    rd("cnt_ffff", 16'hFF04, 16'hFFFF);
    rd("cnt_wrap", 16'hFF04, 16'h0000);
    rd("wrap_noflag", 16'hFF08, 16'h0000);
    wr(16'hFF04, 16'h0100);
    rd("cnt_load", 16'hFF04, 16'h0100);
    rd("cnt_inc", 16'hFF04, 16'h0101);

    switches = 8'hA5;
    rd("sw_lat1", 16'hFF02, 16'h0000);
    rd("sw_lat2", 16'hFF02, 16'h0000);
    rd("sw_val", 16'hFF02, 16'h00A5);
    wr(16'hFF00, 16'h01FF);
    check("leds_ff", {8'h00, leds}, 16'h00FF);
    rd("led_rb", 16'hFF00, 16'h00FF);

    wr(16'hFF04, 16'h0300);
    wr(16'hFF06, 16'h0301);
    step();
    check("irq_pre_rst", {15'h0, timer_irq}, 16'h0001);
    reset     = 1'b1;
    dmemaddr  = 16'hFF00;
    dmemwdata = 16'h00AA;
    dmemwrite = 1'b1;
    step();
    reset     = 1'b0;
    dmemwrite = 1'b0;
    check("rst_leds2", {8'h00, leds}, 16'h0000);
    check("rst_irq2", {15'h0, timer_irq}, 16'h0000);
    rd("rst_count2", 16'hFF04, 16'h0000);
    rd("rst_led2", 16'hFF00, 16'h0000);
    rd("ram_kept", 16'h0010, 16'h9999);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
